// File: rtl/irq_ctrl_if.sv
// Signal bundle between irq_ctrl and its neighbours (fetch, keyboard, Ethernet).
// IRQ_CNT_EN adds the per-source dispatch counters key_cnt/eth_cnt.
interface irq_ctrl_if;
  localparam int unsigned CNT_W = 16;

  logic             key_irq_raw;
  logic             eth_irq;
  logic             int_en;
  logic             branch;
  logic             rti;
  logic             interrupt_key;
  logic             interrupt_eth;
  logic             in_isr;
  logic [1:0]       isr_src;
  logic             pend_key;
  logic             pend_eth;
  logic             spurious_rti;
`ifdef IRQ_CNT_EN
  logic [CNT_W-1:0] key_cnt;
  logic [CNT_W-1:0] eth_cnt;
`endif

  // Environment side: sources, fetch control, observers
  modport master (
    output key_irq_raw, eth_irq, int_en, branch, rti,
    input  interrupt_key, interrupt_eth, in_isr, isr_src,
           pend_key, pend_eth, spurious_rti
`ifdef IRQ_CNT_EN
   ,input  key_cnt, eth_cnt
`endif
  );

  // Controller side
  modport slave (
    input  key_irq_raw, eth_irq, int_en, branch, rti,
    output interrupt_key, interrupt_eth, in_isr, isr_src,
           pend_key, pend_eth, spurious_rti
`ifdef IRQ_CNT_EN
   ,output key_cnt, eth_cnt
`endif
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller ahead of fetch: syncs/latches key and eth events, arbitrates
// (eth first), blocks nesting until rti. IRQ_CNT_EN adds saturating dispatch counters.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  irq_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, DISPATCH, IN_ISR} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_prev_q;
  logic                   pend_key_q, pend_key_d;
  logic                   pend_eth_q, pend_eth_d;
  logic                   int_key_q, int_key_d;
  logic                   int_eth_q, int_eth_d;
  logic                   in_isr_q, in_isr_d;
  logic [1:0]             src_q, src_d;
  logic                   spur_q, spur_d;
  logic                   key_evt_c;
`ifdef IRQ_CNT_EN
  logic [CNT_W-1:0]       key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0]       eth_cnt_q, eth_cnt_d;
`endif

  // Synchronised rising edge of the raw key level
  assign key_evt_c = sync_q[SYNC_STAGES-1] & ~key_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      key_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.key_irq_raw};
      key_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_key_q <= 1'b0;
      pend_eth_q <= 1'b0;
      int_key_q  <= 1'b0;
      int_eth_q  <= 1'b0;
      in_isr_q   <= 1'b0;
      src_q      <= 2'b00;
      spur_q     <= 1'b0;
`ifdef IRQ_CNT_EN
      key_cnt_q  <= '0;
      eth_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_key_q <= pend_key_d;
      pend_eth_q <= pend_eth_d;
      int_key_q  <= int_key_d;
      int_eth_q  <= int_eth_d;
      in_isr_q   <= in_isr_d;
      src_q      <= src_d;
      spur_q     <= spur_d;
`ifdef IRQ_CNT_EN
      key_cnt_q  <= key_cnt_d;
      eth_cnt_q  <= eth_cnt_d;
`endif
    end
  end

  // Next state and next register values; a new event on the winning source
  // in the dispatch cycle keeps its pending bit set.
  always_comb begin
    state_d    = state_q;
    pend_key_d = pend_key_q | key_evt_c;
    pend_eth_d = pend_eth_q | bus.eth_irq;
    int_key_d  = 1'b0;
    int_eth_d  = 1'b0;
    in_isr_d   = in_isr_q;
    src_d      = src_q;
    spur_d     = spur_q;
`ifdef IRQ_CNT_EN
    key_cnt_d  = key_cnt_q;
    eth_cnt_d  = eth_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rti) spur_d = 1'b1;
        if (bus.int_en && (pend_key_q || pend_eth_q) && !bus.branch) begin
          state_d  = DISPATCH;
          in_isr_d = 1'b1;
          if (pend_eth_q) begin
            int_eth_d  = 1'b1;
            src_d      = 2'b10;
            pend_eth_d = bus.eth_irq;
`ifdef IRQ_CNT_EN
            if (eth_cnt_q != {CNT_W{1'b1}}) eth_cnt_d = eth_cnt_q + CNT_W'(1);
`endif
          end else begin
            int_key_d  = 1'b1;
            src_d      = 2'b01;
            pend_key_d = key_evt_c;
`ifdef IRQ_CNT_EN
            if (key_cnt_q != {CNT_W{1'b1}}) key_cnt_d = key_cnt_q + CNT_W'(1);
`endif
          end
        end
      end
      DISPATCH: begin
        if (bus.rti) spur_d = 1'b1;
        state_d = IN_ISR;
      end
      IN_ISR: begin
        if (bus.rti) begin
          state_d  = IDLE;
          in_isr_d = 1'b0;
          src_d    = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.interrupt_key = int_key_q;
  assign bus.interrupt_eth = int_eth_q;
  assign bus.in_isr        = in_isr_q;
  assign bus.isr_src       = src_q;
  assign bus.pend_key      = pend_key_q;
  assign bus.pend_eth      = pend_eth_q;
  assign bus.spurious_rti  = spur_q;
`ifdef IRQ_CNT_EN
  assign bus.key_cnt       = key_cnt_q;
  assign bus.eth_cnt       = eth_cnt_q;
`endif
endmodule
